// File: rtl/eb_pkg.sv
// eb_pkg: shared helpers and defaults for the eb_fifo elastic buffer.
// Optional feature macro used by eb_fifo: EB_FIFO_LEVEL_EN.
package eb_pkg;

    // Default payload width for an elastic buffer stage
    localparam int EB_DEFAULT_DWIDTH = 32;

    // Pointer width: index bits plus one wrap bit
    function automatic int EB_PTR_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/eb_ptr.sv
// eb_ptr: wrap-bit pointer register. 'load' has priority over 'inc';
// incrementing past the top naturally wraps modulo 2**W.
module eb_ptr
    import eb_pkg::*;
#(
    parameter int W = EB_PTR_W(4)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    // Pointer state: reset to zero, load overrides increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/eb_fifo.sv
// eb_fifo: DEPTH-entry valid/ready elastic buffer. t_ready, i_valid,
// t_afull and i_data all come from registered state only, so both the
// forward and the ready paths are broken. flush empties the buffer by
// snapping the read pointer onto the write pointer.
// Optional feature: define EB_FIFO_LEVEL_EN to expose the occupancy port 'level'.
module eb_fifo
    import eb_pkg::*;
#(
    parameter int DWIDTH = EB_DEFAULT_DWIDTH,
    parameter int DEPTH  = 4,
    parameter int AFULL  = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [DWIDTH-1:0]      t_data,
    input  logic                   t_valid,
    output logic                   t_ready,
    output logic                   t_afull,
    output logic [DWIDTH-1:0]      i_data,
    output logic                   i_valid,
    input  logic                   i_ready
`ifdef EB_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int PW = EB_PTR_W(DEPTH);
    localparam int IW = PW - 1;
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL);

    typedef logic [PW-1:0] eb_ptr_t;

    eb_ptr_t           wp;
    eb_ptr_t           rp;
    eb_ptr_t           occ;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] mem [DEPTH];

    // Status from pointers: equal means empty, same index with opposite wrap means full
    always_comb begin
        empty = (wp == rp);
        full  = (wp[IW-1:0] == rp[IW-1:0]) && (wp[IW] != rp[IW]);
        occ   = wp - rp;
        // flush wins over both handshakes; a push in the flush cycle is dropped
        push  = t_valid & ~full & ~flush;
        pop   = i_ready & ~empty & ~flush;
    end

    assign t_ready = ~full;
    assign i_valid = ~empty;
    assign t_afull = (occ >= AFULL_P);
    assign i_data  = mem[rp[IW-1:0]];

`ifdef EB_FIFO_LEVEL_EN
    assign level = occ;
`endif

    eb_ptr #(.W(PW)) u_wptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (push),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wp)
    );

    eb_ptr #(.W(PW)) u_rptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (pop),
        .load     (flush),
        .load_val (wp),
        .ptr      (rp)
    );

    // Storage: cleared on reset, written at the write index on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wp[IW-1:0]] <= t_data;
        end
    end

endmodule

// File: tb/tb_eb_fifo.sv
// tb_eb_fifo: directed and scoreboarded checks of eb_fifo (DEPTH=4, AFULL=3).
module tb_eb_fifo;

    localparam int DW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] t_data;
    logic          t_valid;
    logic          t_ready;
    logic          t_afull;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_ready;
`ifdef EB_FIFO_LEVEL_EN
    logic [2:0]    level;
`endif

    int checks   = 0;
    int failures = 0;

    eb_fifo #(.DWIDTH(DW), .DEPTH(DP), .AFULL(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .t_data  (t_data),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .t_afull (t_afull),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready)
`ifdef EB_FIFO_LEVEL_EN
        ,
        .level   (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; t_valid = 1'b0; t_data = '0; i_ready = 1'b0;
        repeat (2) step();
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL reset_i_valid got=%b exp=0", i_valid); end
        checks++; if (t_ready !== 1'b1) begin failures++; $display("FAIL reset_t_ready got=%b exp=1", t_ready); end
        checks++; if (t_afull !== 1'b0) begin failures++; $display("FAIL reset_t_afull got=%b exp=0", t_afull); end
        checks++; if (i_data !== 32'h0) begin failures++; $display("FAIL reset_i_data got=%h exp=0", i_data); end
`ifdef EB_FIFO_LEVEL_EN
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_fill();
        logic [3:0] exp_afull;
        logic [3:0] exp_ready;
        exp_afull = 4'b1100;   // afull after pushes 3 and 4
        exp_ready = 4'b0111;   // not ready only after push 4
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t_valid = 1'b1;
            t_data  = 32'hA0 + k;
            step();
            checks++; if (i_valid !== 1'b1) begin failures++; $display("FAIL fill_i_valid push=%0d got=%b exp=1", k + 1, i_valid); end
            checks++; if (t_afull !== exp_afull[k]) begin failures++; $display("FAIL fill_t_afull push=%0d got=%b exp=%b", k + 1, t_afull, exp_afull[k]); end
            checks++; if (t_ready !== exp_ready[k]) begin failures++; $display("FAIL fill_t_ready push=%0d got=%b exp=%b", k + 1, t_ready, exp_ready[k]); end
`ifdef EB_FIFO_LEVEL_EN
            checks++; if (level !== 3'(k + 1)) begin failures++; $display("FAIL fill_level push=%0d got=%0d exp=%0d", k + 1, level, k + 1); end
`endif
        end
        // Producer keeps offering a fifth word while full; it must not be taken
        t_data = 32'hBAD;
        step();
        checks++; if (t_ready !== 1'b0) begin failures++; $display("FAIL full_hold_t_ready got=%b exp=0", t_ready); end
        checks++; if (i_data !== 32'hA0) begin failures++; $display("FAIL full_head got=%h exp=a0", i_data); end
        t_valid = 1'b0;
    endtask

    task automatic test_drain();
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (i_valid !== 1'b1) begin failures++; $display("FAIL drain_i_valid pop=%0d got=%b exp=1", k + 1, i_valid); end
            checks++; if (i_data !== 32'hA0 + k) begin failures++; $display("FAIL drain_i_data pop=%0d got=%h exp=%h", k + 1, i_data, 32'hA0 + k); end
            step();
            checks++; if (t_ready !== 1'b1) begin failures++; $display("FAIL drain_t_ready pop=%0d got=%b exp=1", k + 1, t_ready); end
        end
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", i_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] q[$];
        logic [DW-1:0] nxt;
        int            nout;
        nxt  = 32'h1000;
        nout = 0;
        i_ready = 1'b1;
        for (int c = 0; c < 102; c++) begin
            if (c >= 1) begin
                checks++; if (i_valid !== 1'b1 && c <= 100) begin failures++; $display("FAIL stream_bubble cycle=%0d got=%b exp=1", c, i_valid); end
            end
            checks++; if (i_valid !== (q.size() != 0)) begin failures++; $display("FAIL stream_i_valid cycle=%0d got=%b exp=%b", c, i_valid, q.size() != 0); end
`ifdef EB_FIFO_LEVEL_EN
            checks++; if (level > 3'd1) begin failures++; $display("FAIL stream_level cycle=%0d got=%0d exp<=1", c, level); end
`endif
            t_valid = (c < 100);
            t_data  = nxt;
            if (q.size() != 0) begin
                checks++; if (i_data !== q[0]) begin failures++; $display("FAIL stream_data cycle=%0d got=%h exp=%h", c, i_data, q[0]); end
                void'(q.pop_front());
                nout++;
            end
            if (t_valid) begin
                q.push_back(nxt);
                nxt++;
            end
            step();
        end
        t_valid = 1'b0;
        checks++; if (nout != 100) begin failures++; $display("FAIL stream_count got=%0d exp=100", nout); end
        i_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic          hold;
        logic          push;
        logic          pop;
        hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            checks++; if (t_ready !== (q.size() < DP)) begin failures++; $display("FAIL rand_t_ready cycle=%0d got=%b exp=%b", c, t_ready, q.size() < DP); end
            checks++; if (i_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_i_valid cycle=%0d got=%b exp=%b", c, i_valid, q.size() != 0); end
            checks++; if (t_afull !== (q.size() >= 3)) begin failures++; $display("FAIL rand_t_afull cycle=%0d got=%b exp=%b", c, t_afull, q.size() >= 3); end
            if (!hold) begin
                t_valid = 1'($urandom_range(0, 1));
                t_data  = $urandom;
            end
            i_ready = 1'($urandom_range(0, 1));
            push = t_valid && (q.size() < DP);
            pop  = i_ready && (q.size() != 0);
            if (pop) begin
                checks++; if (i_data !== q[0]) begin failures++; $display("FAIL rand_data cycle=%0d got=%h exp=%h", c, i_data, q[0]); end
                void'(q.pop_front());
            end
            if (push) q.push_back(t_data);
            hold = t_valid && !push;
            step();
        end
        // Drain leftovers so later tests start empty
        t_valid = 1'b0;
        i_ready = 1'b1;
        while (q.size() != 0) begin
            checks++; if (i_data !== q[0]) begin failures++; $display("FAIL rand_drain got=%h exp=%h", i_data, q[0]); end
            void'(q.pop_front());
            step();
        end
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL rand_end_empty got=%b exp=0", i_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t_valid = 1'b1;
            t_data  = 32'hC0 + k;
            step();
        end
        flush   = 1'b1;
        t_data  = 32'hFF;
        step();
        flush   = 1'b0;
        t_valid = 1'b0;
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL flush_i_valid got=%b exp=0", i_valid); end
        checks++; if (t_ready !== 1'b1) begin failures++; $display("FAIL flush_t_ready got=%b exp=1", t_ready); end
        checks++; if (t_afull !== 1'b0) begin failures++; $display("FAIL flush_t_afull got=%b exp=0", t_afull); end
`ifdef EB_FIFO_LEVEL_EN
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
`endif
        i_ready = 1'b1;
        repeat (3) begin
            step();
            checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL flush_stays_empty got=%b exp=0", i_valid); end
        end
        t_valid = 1'b1;
        t_data  = 32'h11;
        step();
        t_valid = 1'b0;
        checks++; if (i_valid !== 1'b1 || i_data !== 32'h11) begin failures++; $display("FAIL flush_next_word got=%b/%h exp=1/11", i_valid, i_data); end
        step();
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ff got=%b/%h exp=0", i_valid, i_data); end
        i_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t_valid = 1'b1;
            t_data  = 32'hD0 + k;
            step();
        end
        t_valid = 1'b0;
        checks++; if (i_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b exp=1", i_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL arst_i_valid got=%b exp=0", i_valid); end
        checks++; if (t_ready !== 1'b1) begin failures++; $display("FAIL arst_t_ready got=%b exp=1", t_ready); end
        checks++; if (i_data !== 32'h0) begin failures++; $display("FAIL arst_i_data got=%h exp=0", i_data); end
        #1 rst = 1'b0;
        t_valid = 1'b1;
        t_data  = 32'h55;
        step();
        t_valid = 1'b0;
        checks++; if (i_valid !== 1'b1 || i_data !== 32'h55) begin failures++; $display("FAIL arst_first_push got=%b/%h exp=1/55", i_valid, i_data); end
        i_ready = 1'b1;
        step();
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL arst_only_one got=%b exp=0", i_valid); end
        i_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_random();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
